// File: rtl/seq_shifter_if.sv
// Request/response bundle for seq_shifter: operand, op and amount in,
// shifted value and error flag out, each side with valid/ready.
interface seq_shifter_if #(
  parameter int WIDTH = 32
) ();
  localparam int AMT_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in;
  logic [2:0]       shiftop;
  logic [AMT_W-1:0] shiftamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (
    output in_valid, in, shiftop, shiftamt, out_ready,
    input  in_ready, out_valid, result, err
  );

  modport slave (
    input  in_valid, in, shiftop, shiftamt, out_ready,
    output in_ready, out_valid, result, err
  );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shifter/rotator: moves up to STEP bit positions per cycle
// until the requested amount is consumed, then presents the result.
module seq_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic          clock,
  input  logic          reset,
  seq_shifter_if.slave  bus
);
  localparam int AMT_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);
  localparam logic [AMT_W:0]   WIDTH_A = (AMT_W+1)'(WIDTH);

  localparam logic [2:0] OP_SRL = 3'b000;
  localparam logic [2:0] OP_SRA = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [2:0]       op_q, op_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] src;
  logic [2:0]       src_op;
  logic [AMT_W-1:0] src_rem;
  logic [AMT_W-1:0] k;
  logic [AMT_W:0]   kc;
  logic [WIDTH-1:0] stepped;
  logic             illegal;

  // One step of the op. In IDLE the step works on the incoming request so
  // the first step lands on the accept edge; after that it works on the
  // working register. This is what makes latency ceil(amt/STEP), min 1.
  // Arithmetic right keeps the original MSB because the sign bit of the
  // working register is never overwritten by an arithmetic step.
  always_comb begin
    src     = work_q;
    src_op  = op_q;
    src_rem = rem_q;
    if (state_q == S_IDLE) begin
      src     = bus.in;
      src_op  = bus.shiftop;
      src_rem = bus.shiftamt;
    end
    k       = (src_rem < STEP_A) ? src_rem : STEP_A;
    kc      = WIDTH_A - {1'b0, k};
    illegal = (src_op > OP_ROL);
    case (src_op)
      OP_SRL:  stepped = src >> k;
      OP_SRA:  stepped = $signed(src) >>> k;
      OP_SLL:  stepped = src << k;
      OP_ROR:  stepped = (src >> k) | (src << kc);
      OP_ROL:  stepped = (src << k) | (src >> kc);
      default: stepped = '0;
    endcase
  end

  // Sequencing: accept in IDLE, step in SHIFT, hold in DONE until taken.
  // rem tracks what is left after the step already applied this edge.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    op_d    = op_q;
    rem_d   = rem_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          op_d  = bus.shiftop;
          err_d = 1'b0;
          if (illegal) begin
            work_d  = '0;
            rem_d   = '0;
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            work_d  = stepped;
            rem_d   = src_rem - k;
            state_d = (src_rem == k) ? S_DONE : S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        work_d = stepped;
        rem_d  = rem_q - k;
        if (rem_q == k) state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any request in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      op_q    <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = work_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: directed cases plus randomized requests with
// back-pressure on several (WIDTH, STEP) builds, checked against a
// one-shot shift/rotate model.
module tb_seq_shifter;
  localparam int NCFG = 5;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  logic [NCFG-1:0]       drv_valid;
  logic [NCFG-1:0]       drv_oready;
  logic [NCFG-1:0][63:0] drv_in;
  logic [NCFG-1:0][2:0]  drv_op;
  logic [NCFG-1:0][5:0]  drv_amt;

  wire  [NCFG-1:0]       o_ir;
  wire  [NCFG-1:0]       o_ov;
  wire  [NCFG-1:0]       o_err;
  wire  [NCFG-1:0][63:0] o_res;

  seq_shifter_if #(.WIDTH(32)) if0 ();
  seq_shifter_if #(.WIDTH(32)) if1 ();
  seq_shifter_if #(.WIDTH(32)) if2 ();
  seq_shifter_if #(.WIDTH(16)) if3 ();
  seq_shifter_if #(.WIDTH(64)) if4 ();

  seq_shifter #(.WIDTH(32), .STEP(1))  u0 (.clock(clock), .reset(reset), .bus(if0));
  seq_shifter #(.WIDTH(32), .STEP(8))  u1 (.clock(clock), .reset(reset), .bus(if1));
  seq_shifter #(.WIDTH(32), .STEP(5))  u2 (.clock(clock), .reset(reset), .bus(if2));
  seq_shifter #(.WIDTH(16), .STEP(15)) u3 (.clock(clock), .reset(reset), .bus(if3));
  seq_shifter #(.WIDTH(64), .STEP(7))  u4 (.clock(clock), .reset(reset), .bus(if4));

  assign if0.in_valid = drv_valid[0];  assign if0.out_ready = drv_oready[0];
  assign if0.in = drv_in[0][31:0];     assign if0.shiftop = drv_op[0];
  assign if0.shiftamt = drv_amt[0][4:0];
  assign o_ir[0] = if0.in_ready;  assign o_ov[0] = if0.out_valid;
  assign o_err[0] = if0.err;      assign o_res[0] = {32'd0, if0.result};

  assign if1.in_valid = drv_valid[1];  assign if1.out_ready = drv_oready[1];
  assign if1.in = drv_in[1][31:0];     assign if1.shiftop = drv_op[1];
  assign if1.shiftamt = drv_amt[1][4:0];
  assign o_ir[1] = if1.in_ready;  assign o_ov[1] = if1.out_valid;
  assign o_err[1] = if1.err;      assign o_res[1] = {32'd0, if1.result};

  assign if2.in_valid = drv_valid[2];  assign if2.out_ready = drv_oready[2];
  assign if2.in = drv_in[2][31:0];     assign if2.shiftop = drv_op[2];
  assign if2.shiftamt = drv_amt[2][4:0];
  assign o_ir[2] = if2.in_ready;  assign o_ov[2] = if2.out_valid;
  assign o_err[2] = if2.err;      assign o_res[2] = {32'd0, if2.result};

  assign if3.in_valid = drv_valid[3];  assign if3.out_ready = drv_oready[3];
  assign if3.in = drv_in[3][15:0];     assign if3.shiftop = drv_op[3];
  assign if3.shiftamt = drv_amt[3][3:0];
  assign o_ir[3] = if3.in_ready;  assign o_ov[3] = if3.out_valid;
  assign o_err[3] = if3.err;      assign o_res[3] = {48'd0, if3.result};

  assign if4.in_valid = drv_valid[4];  assign if4.out_ready = drv_oready[4];
  assign if4.in = drv_in[4];           assign if4.shiftop = drv_op[4];
  assign if4.shiftamt = drv_amt[4];
  assign o_ir[4] = if4.in_ready;  assign o_ov[4] = if4.out_valid;
  assign o_err[4] = if4.err;      assign o_res[4] = if4.result;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case a wait somewhere was not bounded tightly enough.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int cfg_w(input int c);
    case (c)
      3:       return 16;
      4:       return 64;
      default: return 32;
    endcase
  endfunction

  function automatic int cfg_step(input int c);
    case (c)
      0:       return 1;
      1:       return 8;
      2:       return 5;
      3:       return 15;
      default: return 7;
    endcase
  endfunction

  // Whole-amount shift/rotate on a w-bit value.
  function automatic logic [63:0] ref_op(input logic [63:0] d, input logic [2:0] op,
                                         input int amt, input int w);
    logic [63:0] m, x, r;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    x = d & m;
    case (op)
      3'd0: r = x >> amt;
      3'd1: begin
        r = x >> amt;
        if (x[w-1]) r = r | (m & ~(m >> amt));
      end
      3'd2:    r = x << amt;
      3'd3:    r = (x >> amt) | (x << (w - amt));
      3'd4:    r = (x << amt) | (x >> (w - amt));
      default: r = '0;
    endcase
    return r & m;
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input int amt, input int step);
    if (op > 3'd4 || amt == 0) return 1;
    return (amt + step - 1) / step;
  endfunction

  task automatic scramble(input int c);
    drv_in[c]  = {$urandom, $urandom};
    drv_op[c]  = 3'($urandom_range(0, 7));
    drv_amt[c] = 6'($urandom_range(0, 63));
  endtask

  // Issue one request (entered and left at a negedge with the DUT idle),
  // wiggle the operand inputs while busy, hold out_ready low for 'hold'
  // cycles checking stability, then release. lat = first cycle after the
  // accept edge (1-based) in which out_valid is seen.
  task automatic run_req(input int c, input logic [63:0] d, input logic [2:0] op,
                         input logic [5:0] amt, input int hold,
                         output logic [63:0] res, output logic e, output int lat);
    res = '0; e = 1'b0; lat = 0;
    drv_in[c] = d; drv_op[c] = op; drv_amt[c] = amt;
    drv_valid[c] = 1'b1; drv_oready[c] = 1'b0;
    checks++;
    if (o_ir[c] !== 1'b1) begin
      failures++;
      $display("FAIL accept_ready cfg=%0d got=%b want=1", c, o_ir[c]);
    end
    @(posedge clock);
    @(negedge clock);
    drv_valid[c] = 1'b0;
    scramble(c);
    lat = 1;
    while (o_ov[c] !== 1'b1 && lat < 200) begin
      @(negedge clock);
      scramble(c);
      lat++;
    end
    if (o_ov[c] !== 1'b1) begin
      checks++; failures++;
      $display("FAIL out_valid_timeout cfg=%0d got=%b want=1 within 200 cycles", c, o_ov[c]);
      lat = -1;
      return;
    end
    res = o_res[c];
    e   = o_err[c];
    for (int i = 0; i < hold; i++) begin
      @(negedge clock);
      scramble(c);
      checks++;
      if (o_ov[c] !== 1'b1 || o_ir[c] !== 1'b0 || o_res[c] !== res || o_err[c] !== e) begin
        failures++;
        $display("FAIL done_hold cfg=%0d got ov=%b ir=%b res=%h err=%b want ov=1 ir=0 res=%h err=%b",
                 c, o_ov[c], o_ir[c], o_res[c], o_err[c], res, e);
      end
    end
    drv_oready[c] = 1'b1;
    @(negedge clock);
    drv_oready[c] = 1'b0;
    checks++;
    if (o_ir[c] !== 1'b1 || o_ov[c] !== 1'b0) begin
      failures++;
      $display("FAIL release cfg=%0d got ir=%b ov=%b want ir=1 ov=0", c, o_ir[c], o_ov[c]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drv_valid = '1; drv_oready = '0;
    for (int c = 0; c < NCFG; c++) scramble(c);
    repeat (3) @(negedge clock);
    drv_valid = '0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    for (int c = 0; c < NCFG; c++) begin
      checks++;
      if (o_ir[c] !== 1'b1 || o_ov[c] !== 1'b0 || o_res[c] !== 64'd0 || o_err[c] !== 1'b0) begin
        failures++;
        $display("FAIL reset_state cfg=%0d got ir=%b ov=%b res=%h err=%b want ir=1 ov=0 res=0 err=0",
                 c, o_ir[c], o_ov[c], o_res[c], o_err[c]);
      end
    end
  endtask

  task automatic test_arith_right();
    logic [63:0] r; logic e; int lat;
    run_req(0, 64'h8000_0001, 3'b001, 6'd4, 0, r, e, lat);
    checks++;
    if (r !== 64'hF800_0000 || e !== 1'b0 || lat != 4) begin
      failures++;
      $display("FAIL sra_step1 got res=%h err=%b lat=%0d want res=f8000000 err=0 lat=4", r, e, lat);
    end
  endtask

  task automatic test_rotate();
    logic [63:0] r; logic e; int lat;
    run_req(1, 64'h1234_5678, 3'b011, 6'd12, 1, r, e, lat);
    checks++;
    if (r !== 64'h6781_2345 || e !== 1'b0 || lat != 2) begin
      failures++;
      $display("FAIL ror_step8 got res=%h err=%b lat=%0d want res=67812345 err=0 lat=2", r, e, lat);
    end
    run_req(1, 64'h1234_5678, 3'b100, 6'd12, 0, r, e, lat);
    checks++;
    if (r !== 64'h4567_8123 || e !== 1'b0 || lat != 2) begin
      failures++;
      $display("FAIL rol_step8 got res=%h err=%b lat=%0d want res=45678123 err=0 lat=2", r, e, lat);
    end
  endtask

  task automatic test_zero_and_illegal();
    logic [63:0] r; logic e; int lat;
    run_req(0, 64'hDEAD_BEEF, 3'b010, 6'd0, 0, r, e, lat);
    checks++;
    if (r !== 64'hDEAD_BEEF || e !== 1'b0 || lat != 1) begin
      failures++;
      $display("FAIL amt_zero got res=%h err=%b lat=%0d want res=deadbeef err=0 lat=1", r, e, lat);
    end
    run_req(0, 64'hDEAD_BEEF, 3'b110, 6'd0, 0, r, e, lat);
    checks++;
    if (r !== 64'd0 || e !== 1'b1 || lat != 1) begin
      failures++;
      $display("FAIL illegal_op got res=%h err=%b lat=%0d want res=0 err=1 lat=1", r, e, lat);
    end
    run_req(0, 64'hDEAD_BEEF, 3'b111, 6'd17, 0, r, e, lat);
    checks++;
    if (r !== 64'd0 || e !== 1'b1 || lat != 1) begin
      failures++;
      $display("FAIL illegal_op_amt got res=%h err=%b lat=%0d want res=0 err=1 lat=1", r, e, lat);
    end
    // Next legal request must clear err.
    run_req(0, 64'h0000_00F0, 3'b000, 6'd4, 0, r, e, lat);
    checks++;
    if (r !== 64'h0000_000F || e !== 1'b0 || lat != 4) begin
      failures++;
      $display("FAIL err_clear got res=%h err=%b lat=%0d want res=f err=0 lat=4", r, e, lat);
    end
  endtask

  task automatic test_hold();
    logic [63:0] r; logic e; int lat;
    run_req(2, 64'hA5A5_0F0F, 3'b010, 6'd9, 5, r, e, lat);
    checks++;
    if (r !== 64'h4A1E_1E00 || e !== 1'b0 || lat != 2) begin
      failures++;
      $display("FAIL hold_result got res=%h err=%b lat=%0d want res=4a1e1e00 err=0 lat=2", r, e, lat);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [63:0] r; logic e; int lat; int seen;
    drv_in[0] = 64'hFFFF_FFFF; drv_op[0] = 3'b000; drv_amt[0] = 6'd31;
    drv_valid[0] = 1'b1; drv_oready[0] = 1'b1;
    @(posedge clock);
    @(negedge clock);
    drv_valid[0] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (o_ir[0] !== 1'b1 || o_ov[0] !== 1'b0 || o_res[0] !== 64'd0 || o_err[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got ir=%b ov=%b res=%h err=%b want ir=1 ov=0 res=0 err=0",
               o_ir[0], o_ov[0], o_res[0], o_err[0]);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (o_ov[0] === 1'b1) seen++;
    end
    drv_oready[0] = 1'b0;
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL reset_discard got out_valid_cycles=%0d want 0", seen);
    end
    run_req(0, 64'h1234_5678, 3'b011, 6'd8, 1, r, e, lat);
    checks++;
    if (r !== 64'h7812_3456 || e !== 1'b0 || lat != 8) begin
      failures++;
      $display("FAIL after_reset got res=%h err=%b lat=%0d want res=78123456 err=0 lat=8", r, e, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] r; logic e; int lat;
    for (int i = 0; i < 4; i++) begin
      logic [63:0] d; logic [2:0] op; int amt;
      d = {32'd0, $urandom}; op = 3'(i); amt = 31 - i;
      run_req(2, d, op, 6'(amt), 0, r, e, lat);
      checks++;
      if (r !== ref_op(d, op, amt, 32) || e !== 1'b0 || lat != ref_lat(op, amt, 5)) begin
        failures++;
        $display("FAIL back_to_back i=%0d got res=%h err=%b lat=%0d want res=%h err=0 lat=%0d",
                 i, r, e, lat, ref_op(d, op, amt, 32), ref_lat(op, amt, 5));
      end
    end
  endtask

  task automatic test_random(input int c, input int n);
    logic [63:0] r, d, want; logic e; int lat, w, amt;
    logic [2:0] op;
    w = cfg_w(c);
    for (int i = 0; i < n; i++) begin
      d   = {$urandom, $urandom};
      op  = 3'($urandom_range(0, 7));
      amt = $urandom_range(0, w - 1);
      run_req(c, d, op, 6'(amt), $urandom_range(0, 3), r, e, lat);
      want = ref_op(d, op, amt, w);
      checks++;
      if (r !== want || e !== (op > 3'd4) || lat != ref_lat(op, amt, cfg_step(c))) begin
        failures++;
        $display("FAIL random cfg=%0d in=%h op=%0d amt=%0d got res=%h err=%b lat=%0d want res=%h err=%b lat=%0d",
                 c, d, op, amt, r, e, lat, want, (op > 3'd4), ref_lat(op, amt, cfg_step(c)));
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    drv_valid = '0; drv_oready = '0;
    drv_in = '0; drv_op = '0; drv_amt = '0;
    reset = 1'b1;
    @(negedge clock);
    test_reset();
    test_arith_right();
    test_rotate();
    test_zero_and_illegal();
    test_hold();
    test_reset_mid_shift();
    test_back_to_back();
    test_random(0, 800);
    test_random(2, 800);
    test_random(3, 800);
    test_random(4, 800);
    test_random(1, 300);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seq_shifter.md
SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, datapath width; legal values are powers of two, 4 to 64.
REQ-002 The block SHALL have parameter STEP, default 1, maximum bit positions shifted per cycle; legal values are 1 to WIDTH-1.
REQ-003 The block SHALL derive localparam AMT_W = log2(WIDTH).
REQ-004 Port clock, input, 1, sole clock; all state updates on rising edge.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port in_valid, input, 1, request present.
REQ-007 Port in_ready, output, 1, block can accept a request.
REQ-008 Port in, input, WIDTH, operand.
REQ-009 Port shiftop, input, 3, operation code.
REQ-010 Port shiftamt, input, AMT_W, shift/rotate amount, unsigned.
REQ-011 Port out_valid, output, 1, result available.
REQ-012 Port out_ready, input, 1, consumer takes result.
REQ-013 Port result, output, WIDTH, shifted value.
REQ-014 Port err, output, 1, illegal shiftop flag, qualified by out_valid.

Function
REQ-015 shiftop encoding SHALL be: 000 logical right, 001 arithmetic right (MSB replicated), 010 logical left, 011 rotate right, 100 rotate left; 101-111 illegal.
REQ-016 The FSM SHALL have states IDLE, SHIFT, DONE.
REQ-017 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-018 In IDLE with in_valid=1, the block SHALL latch in, shiftop and shiftamt, set remaining = shiftamt, err = 0, and move to SHIFT; with in_valid=0 it SHALL stay in IDLE.
REQ-019 An accepted request with shiftamt=0 and a legal op SHALL move directly to DONE with result = in.
REQ-020 An accepted request with an illegal op SHALL move directly to DONE with result = 0 and err = 1, regardless of shiftamt.
REQ-021 Each SHIFT cycle SHALL apply the latched op by k = min(STEP, remaining) positions to the working register and SHALL decrement remaining by k.
REQ-022 SHIFT SHALL move to DONE in the cycle where remaining reaches 0.
REQ-023 Latency from accept edge to out_valid=1 SHALL be ceil(shiftamt/STEP) cycles, with a minimum of 1 cycle.
REQ-024 The composed per-cycle operations SHALL produce a result bit-identical to a single shift or rotate by shiftamt; arithmetic right SHALL use the original MSB at every step.
REQ-025 In DONE, result and err SHALL be held stable while out_ready=0.
REQ-026 In DONE with out_ready=1, the block SHALL return to IDLE; in_ready SHALL rise the next cycle, so back-to-back requests have one bubble cycle.
REQ-027 in, shiftop and shiftamt SHALL be ignored outside IDLE; changes during SHIFT or DONE SHALL not affect the result.
REQ-028 result SHALL be driven from the working register in all states, and SHALL be meaningful only while out_valid=1.

Reset
REQ-029 reset=1 at a rising edge SHALL force IDLE, result=0, err=0, out_valid=0, in_ready=1 from the next cycle.
REQ-030 reset SHALL take priority over every other input, including mid-SHIFT and in DONE; any in-flight request SHALL be discarded with no out_valid pulse.

Verification
REQ-031 WIDTH=32, STEP=1, in=0x80000001, op=001, amt=4 -> out_valid 4 cycles after accept, result=0xF8000000, err=0.
REQ-032 WIDTH=32, STEP=8, in=0x12345678, op=011, amt=12 -> latency 2, result=0x67812345; repeat with op=100 -> result=0x45678123.
REQ-033 op=010, amt=0, in=0xDEADBEEF -> latency 1, result=0xDEADBEEF; op=110 -> latency 1, result=0, err=1.
REQ-034 Hold out_ready=0 for 5 cycles in DONE while toggling in, shiftop and shiftamt -> result stable, in_ready=0; out_ready=1 -> IDLE, in_ready=1 the following cycle.
REQ-035 Assert reset in the 3rd cycle of an op=000, amt=31, STEP=1 shift -> next cycle IDLE, out_valid=0, result=0; a following request completes correctly.
REQ-036 A random self-check of 10k requests against a single-step reference model SHALL pass for (WIDTH, STEP) = (32,1), (32,5), (16,15) and (64,7), with random out_ready back-pressure.
